// File: rtl/sum3_seq_pkg.sv
// rtl/sum3_seq_pkg.sv - shared states and mux select encoding for sum3_seq
package sum3_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL_X = 3'd1,
    SEL_Y = 3'd2,
    SEL_Z = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_X_C    = 2'b00;
  localparam logic [1:0] SEL_Y_C    = 2'b01;
  localparam logic [1:0] SEL_Z_C    = 2'b10;
  localparam logic [1:0] SEL_IDLE_C = 2'b11;

  // Mux select driven while the FSM sits in a given state
  function automatic logic [1:0] sel_decode(input state_t s);
    case (s)
      SEL_X:   return SEL_X_C;
      SEL_Y:   return SEL_Y_C;
      SEL_Z:   return SEL_Z_C;
      default: return SEL_IDLE_C;
    endcase
  endfunction

endpackage

// File: rtl/sum3_acc.sv
// rtl/sum3_acc.sv - W+2-bit accumulator with clear, add-enable and hold
module sum3_acc #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] addend,
  output logic [W+1:0] sum
);

  // Clear wins over add; otherwise hold. Three W-bit terms never exceed W+2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + {2'b00, addend};
    end
  end

endmodule

// File: rtl/sum3_seq.sv
// rtl/sum3_seq.sv - steps a 3-to-1 mux through X, Y, Z and accumulates the result
module sum3_seq
  import sum3_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         EN,
  input  logic [W-1:0] O,
  output logic [1:0]   C,
  output logic [W+1:0] SUM,
  output logic         BUSY,
  output logic         DONE
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   add;

  // Next-state and accumulator controls; EN low leaves everything where it is
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    add       = 1'b0;
    if (EN) begin
      case (state)
        IDLE: begin
          if (START) begin
            state_nxt = SEL_X;
            accept    = 1'b1;
          end
        end
        SEL_X: begin
          state_nxt = SEL_Y;
          add       = 1'b1;
        end
        SEL_Y: begin
          state_nxt = SEL_Z;
          add       = 1'b1;
        end
        SEL_Z: begin
          state_nxt = FIN;
          add       = 1'b1;
        end
        FIN: begin
          if (START) begin
            state_nxt = SEL_X;
            accept    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State plus registered decodes taken from the next state, so C never glitches
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      C     <= SEL_IDLE_C;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      C     <= sel_decode(state_nxt);
      BUSY  <= (state_nxt == SEL_X) || (state_nxt == SEL_Y) || (state_nxt == SEL_Z);
      DONE  <= (state_nxt == FIN);
    end
  end

  sum3_acc #(
    .W(W)
  ) u_acc (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (accept),
    .add    (add),
    .addend (O),
    .sum    (SUM)
  );

endmodule

// File: tb/tb_sum3_seq.sv
// tb/tb_sum3_seq.sv - randomized self-checking bench for sum3_seq
module tb_sum3_seq;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       EN;
  logic [3:0] O;
  logic [1:0] C;
  logic [5:0] SUM;
  logic       BUSY;
  logic       DONE;
  logic [3:0] X, Y, Z;

  int checks = 0;
  int errors = 0;

  sum3_seq #(.W(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .EN    (EN),
    .O     (O),
    .C     (C),
    .SUM   (SUM),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 3-to-1 source mux in front of the DUT
  always_comb begin
    case (C)
      2'b00:   O = X;
      2'b01:   O = Y;
      2'b10:   O = Z;
      default: O = 4'd0;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_sum);
    check({tag, "_c"}, C, 3);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_sum"}, SUM, exp_sum);
  endtask

  // Accept a START from IDLE or FIN; the first select cycle follows immediately
  task automatic start_edge(input int x, input int y, input int z);
    X = x[3:0]; Y = y[3:0]; Z = z[3:0];
    START = 1'b1;
    EN = 1'b1;
    tick();
    START = 1'b0;
    check("start_c", C, 0);
    check("start_sum", SUM, 0);
    check("start_busy", BUSY, 1);
    check("start_done", DONE, 0);
  endtask

  // Walk the three selects with EN=0 on iterations flagged in mask; ends in FIN
  task automatic run_body(input int x, input int y, input int z,
                          input logic [31:0] mask, input bit hold);
    int vals[3];
    int idx;
    int cyc;
    int stalls;
    int partial;
    int it;
    vals = '{x, y, z};
    idx = 0;
    cyc = 1;
    stalls = 0;
    it = 0;
    while (idx < 3 && it < 64) begin
      EN = (it < 32) ? ~mask[it] : 1'b1;
      START = hold;
      tick();
      cyc++;
      if (EN) idx++;
      else stalls++;
      it++;
      partial = 0;
      for (int k = 0; k < idx; k++) partial += vals[k];
      if (idx < 3) begin
        check("sel_c", C, idx);
        check("sel_busy", BUSY, 1);
        check("sel_done", DONE, 0);
        check("sel_sum", SUM, partial);
      end
    end
    START = 1'b0;
    check("fin_reached", idx, 3);
    check("fin_c", C, 3);
    check("fin_done", DONE, 1);
    check("fin_busy", BUSY, 0);
    check("fin_sum", SUM, x + y + z);
    check("fin_latency", cyc, 4 + stalls);
  endtask

  task automatic finish_idle(input int exp_sum);
    EN = 1'b1;
    START = 1'b0;
    tick();
    check_idle("after_fin", exp_sum);
  endtask

  initial begin
    int x, y, z;
    RST_N = 1'b0;
    START = 1'b0;
    EN = 1'b0;
    X = '0; Y = '0; Z = '0;
    #12;
    check_idle("reset", 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Idle with START low
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle", 0);
    end

    // Basic sum
    start_edge(3, 5, 9);
    run_body(3, 5, 9, 32'h0, 1'b0);
    finish_idle(17);

    // Maximum values, with an EN=0 cycle in FIN keeping DONE high
    start_edge(15, 15, 15);
    run_body(15, 15, 15, 32'h0, 1'b0);
    EN = 1'b0;
    tick();
    check("fin_stall_done", DONE, 1);
    check("fin_stall_c", C, 3);
    check("fin_stall_sum", SUM, 45);

    // Back-to-back from FIN, two-cycle stall in SEL_Y
    start_edge(7, 2, 11);
    run_body(7, 2, 11, 32'h6, 1'b0);
    finish_idle(20);

    // START held high through the busy phase
    start_edge(1, 14, 6);
    run_body(1, 14, 6, 32'h0, 1'b1);
    finish_idle(21);

    // START with EN low in IDLE is not accepted
    START = 1'b1;
    EN = 1'b0;
    tick();
    START = 1'b0;
    check_idle("start_en0", 21);
    EN = 1'b1;
    tick();
    check_idle("start_en0_after", 21);

    // Asynchronous reset in SEL_Z
    start_edge(9, 9, 9);
    tick();
    tick();
    check("pre_rst_c", C, 2);
    #2;
    RST_N = 1'b0;
    #1;
    check_idle("mid_rst", 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_rst", 0);
    end
    start_edge(4, 8, 12);
    run_body(4, 8, 12, 32'h0, 1'b0);
    finish_idle(24);

    // Randomized transactions with random stalls, START holds and chaining
    x = $urandom_range(15); y = $urandom_range(15); z = $urandom_range(15);
    start_edge(x, y, z);
    for (int t = 0; t < 24; t++) begin
      logic [31:0] m;
      m = $urandom & $urandom & 32'hFF;
      run_body(x, y, z, m, 1'($urandom_range(1)));
      if ($urandom_range(1) == 1) begin
        x = $urandom_range(15); y = $urandom_range(15); z = $urandom_range(15);
        start_edge(x, y, z);
      end else begin
        finish_idle(x + y + z);
        x = $urandom_range(15); y = $urandom_range(15); z = $urandom_range(15);
        start_edge(x, y, z);
      end
    end
    run_body(x, y, z, 32'h0, 1'b0);
    finish_idle(x + y + z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum3_seq.md
# sum3_seq

Sequencing controller that sits directly around the 4-bit 3-to-1 source mux. It drives the mux select, steps it through sources X, Y and Z on a start request, and accumulates the returned mux output into a sum register. It is the control and datapath stage that both feeds the mux (select) and consumes its result (accumulated sum), with a done pulse and a stall input.

## Interface

- W, default 4: mux data width; SUM is W+2 bits.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous, active-low.
- START  input  1  request a new 3-source accumulation; sampled on rising CLK.
- EN  input  1  advance enable. When low, the FSM, SUM and C all freeze.
- O  input  W  mux output, combinational from C; sampled in SEL states.
- C  output  2  mux select: 00=X, 01=Y, 10=Z, 11=zero/idle.
- SUM  output  W+2  accumulated X+Y+Z.
- BUSY  output  1  high in SEL_X, SEL_Y and SEL_Z.
- DONE  output  1  one-cycle pulse when SUM becomes valid.

## Operation

- States:
  - IDLE: C=11, BUSY=0. Goes to SEL_X on START=1 and EN=1; SUM is cleared to 0 on the same edge.
  - SEL_X: C=00. On the EN edge, SUM <= SUM + O, then go to SEL_Y.
  - SEL_Y: C=01. On the EN edge, add O, then go to SEL_Z.
  - SEL_Z: C=10. On the EN edge, add O, then go to FIN.
  - FIN: C=11, DONE=1. On the EN edge go to IDLE, or straight to SEL_X (clearing SUM) if START=1.
- Arithmetic:
  - O is zero-extended to W+2 bits; the sum is unsigned.
  - The maximum is 3·(2^W−1), which fits in W+2 bits, so there is no overflow path.
- SUM holds its value in IDLE and FIN until the next accepted START.
- START is ignored while BUSY=1; it is not queued.
- EN=0 in any state:
  - state, C and SUM are held;
  - DONE stays high if already in FIN. DONE is a state decode, so it lasts exactly one enabled cycle.
- C is a registered, glitch-free state decode. The mux must never see 11 in a SEL state.

## Timing

- Reset (RST_N low, asynchronous): state=IDLE, C=11, SUM=0, BUSY=0, DONE=0. Deasserting reset has effect from the next rising edge.
- Latency with EN held high:
  - START sampled at edge 0;
  - C=00 during cycle 1, 01 during cycle 2, 10 during cycle 3;
  - DONE=1 and final SUM during cycle 4.
- O is sampled at the end of each SEL cycle: same-cycle combinational return, with no extra pipeline register.
- Back-to-back: START high during FIN gives C=00 in the very next cycle and SUM cleared. Throughput is one result per 4 cycles.
- Reset mid-sequence: asynchronous return to the reset values; the partial sum is discarded and no DONE is issued.
- START and EN=0 in the same cycle in IDLE: not accepted.

## Structure

- Shared package:
  - state enum (IDLE, SEL_X, SEL_Y, SEL_Z, FIN);
  - select constants SEL_X_C=2'b00, SEL_Y_C=2'b01, SEL_Z_C=2'b10, SEL_IDLE_C=2'b11. The mux select encoding is defined here and nowhere else.
- One natural sub-module, sum3_acc: the W+2-bit accumulator register with clear, add-enable and hold. The FSM and output decode stay in sum3_seq.

## Test plan

- Reset then idle: RST_N low → C=11, SUM=0, BUSY=0, DONE=0. With START=0 for 10 cycles, the outputs are unchanged.
- Basic sum: X=3, Y=5, Z=9 through the 3-to-1 mux, START pulse → C sequence 00, 01, 10; DONE in cycle 4; SUM=17.
- Max values: X=Y=Z=15 → SUM=45 (6'b101101); no wrap.
- Stall: EN=0 for 2 cycles while in SEL_Y → C stays 01 and SUM is held. Result is still X+Y+Z, and DONE is delayed by exactly 2 cycles.
- START handling:
  - START held high during BUSY → ignored.
  - START high in FIN → next cycle C=00, SUM=0, with no IDLE cycle in between.
- Mid-sequence reset: RST_N pulsed low in SEL_Z → C=11, SUM=0 immediately (asynchronous), no DONE. A new START afterwards produces a correct sum.
